// File: rtl/qdrii_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : qdrii_arb_pkg
// Purpose : Shared defaults, tag-width helper and error-bit indices for the
//           QDRII user-port arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package qdrii_arb_pkg;

    localparam int c_num_req_default   = 4;
    localparam int c_addr_w_default    = 19;
    localparam int c_data_w_default    = 144;
    localparam int c_tag_depth_default = 32;

    localparam int c_err_orphan   = 0;
    localparam int c_err_cal_lost = 1;

    function automatic int tag_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Purpose : One-hot round-robin arbiter; search starts after the last grant.
// Rev     : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int c_idx_w = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(N - 1);

    // r_ptr is the highest-priority index for the current cycle
    logic [c_idx_w-1:0] r_ptr;
    logic [c_idx_w-1:0] w_k;
    logic [c_idx_w-1:0] w_next;
    logic               w_found;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_next  = r_ptr;
        w_k     = '0;
        for (int i = 0; i < N; i++) begin
            w_k = c_idx_w'((int'(r_ptr) + i) % N);
            if (!w_found && req[w_k]) begin
                w_found    = 1'b1;
                grant[w_k] = 1'b1;
                w_next     = (w_k == c_last_idx) ? '0 : w_k + c_idx_w'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance && w_found) begin
            r_ptr <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/qdrii_user_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : qdrii_user_arbiter
// Purpose : Shares one QDRII controller among NUM_REQ requesters with separate
//           read/write round-robin arbiters and an in-order read tag FIFO.
// Rev     : 1.0  initial release
// ============================================================================
module qdrii_user_arbiter
    import qdrii_arb_pkg::*;
#(
    parameter int NUM_REQ   = c_num_req_default,
    parameter int ADDR_W    = c_addr_w_default,
    parameter int DATA_W    = c_data_w_default,
    parameter int TAG_DEPTH = c_tag_depth_default
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cal_done,
    input  logic [NUM_REQ-1:0]          req_wr_valid,
    output logic [NUM_REQ-1:0]          req_wr_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_wr_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wr_data,
    input  logic [NUM_REQ-1:0]          req_rd_valid,
    output logic [NUM_REQ-1:0]          req_rd_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_rd_addr,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        qdr_wr_cmd,
    output logic [ADDR_W-1:0]           qdr_wr_addr,
    output logic [DATA_W-1:0]           qdr_wr_data,
    input  logic                        qdr_wr_full,
    output logic                        qdr_rd_cmd,
    output logic [ADDR_W-1:0]           qdr_rd_addr,
    input  logic                        qdr_rd_full,
    input  logic                        qdr_rd_valid,
    input  logic [DATA_W-1:0]           qdr_rd_data,
    output logic [1:0]                  err_flags,
    input  logic                        err_clr,
    output logic [tag_w(TAG_DEPTH):0]   rd_outstanding
);

    localparam int c_tag_w = tag_w(TAG_DEPTH);
    localparam int c_req_w = $clog2(NUM_REQ);
    localparam logic [c_tag_w:0] c_tag_full = (c_tag_w + 1)'(TAG_DEPTH);

    logic [NUM_REQ-1:0] w_wr_elig, w_rd_elig;
    logic [NUM_REQ-1:0] w_wr_grant, w_rd_grant;
    logic               w_wr_gate, w_rd_gate;
    logic               w_wr_accept, w_rd_accept;
    logic [c_req_w-1:0] w_rd_idx;
    logic [ADDR_W-1:0]  w_wr_addr_sel, w_rd_addr_sel;
    logic [DATA_W-1:0]  w_wr_data_sel;

    logic [c_req_w-1:0] r_tag_mem [TAG_DEPTH];
    logic [c_tag_w-1:0] r_wptr, r_rptr;
    logic [c_tag_w:0]   r_count;
    logic               w_tag_empty, w_tag_full;
    logic               w_push, w_pop;
    logic [c_req_w-1:0] w_tag_out;
    logic [NUM_REQ-1:0] w_tag_onehot;

    logic               r_wr_cmd, r_rd_cmd;
    logic [ADDR_W-1:0]  r_wr_addr, r_rd_addr;
    logic [DATA_W-1:0]  r_wr_data, r_rsp_data;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [1:0]         r_err, w_err_new;
    logic               r_cal_d;

    // Full is judged on current occupancy, so a same-cycle pop never opens the gate
    assign w_tag_empty = (r_count == '0);
    assign w_tag_full  = (r_count == c_tag_full);

    assign w_wr_gate = rst_n & cal_done & ~qdr_wr_full;
    assign w_rd_gate = rst_n & cal_done & ~qdr_rd_full & ~w_tag_full;
    assign w_wr_elig = req_wr_valid & {NUM_REQ{w_wr_gate}};
    assign w_rd_elig = req_rd_valid & {NUM_REQ{w_rd_gate}};

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (w_wr_elig),
        .advance (w_wr_accept),
        .grant   (w_wr_grant)
    );

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (w_rd_elig),
        .advance (w_rd_accept),
        .grant   (w_rd_grant)
    );

    assign w_wr_accept  = |w_wr_grant;
    assign w_rd_accept  = |w_rd_grant;
    assign req_wr_ready = w_wr_grant;
    assign req_rd_ready = w_rd_grant;

    always_comb begin
        w_rd_idx      = '0;
        w_wr_addr_sel = '0;
        w_wr_data_sel = '0;
        w_rd_addr_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_wr_grant[i]) begin
                w_wr_addr_sel = req_wr_addr[i*ADDR_W +: ADDR_W];
                w_wr_data_sel = req_wr_data[i*DATA_W +: DATA_W];
            end
            if (w_rd_grant[i]) begin
                w_rd_idx      = c_req_w'(i);
                w_rd_addr_sel = req_rd_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_cmd  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_rd_cmd  <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_wr_cmd <= w_wr_accept;
            r_rd_cmd <= w_rd_accept;
            if (w_wr_accept) begin
                r_wr_addr <= w_wr_addr_sel;
                r_wr_data <= w_wr_data_sel;
            end
            if (w_rd_accept) begin
                r_rd_addr <= w_rd_addr_sel;
            end
        end
    end

    assign w_push    = w_rd_accept;
    assign w_pop     = qdr_rd_valid & ~w_tag_empty;
    assign w_tag_out = r_tag_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_mem[r_wptr] <= w_rd_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_tag_w'(1);
            if (w_pop)  r_rptr <= r_rptr + c_tag_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_tag_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_tag_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_tag_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_tag_onehot[i] = (w_tag_out == c_req_w'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= w_pop ? w_tag_onehot : '0;
            if (w_pop) begin
                r_rsp_data <= qdr_rd_data;
            end
        end
    end

    // A new error in the same cycle as err_clr survives the clear
    always_comb begin
        w_err_new                 = 2'b00;
        w_err_new[c_err_orphan]   = qdr_rd_valid & w_tag_empty;
        w_err_new[c_err_cal_lost] = r_cal_d & ~cal_done & ~w_tag_empty;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err   <= 2'b00;
            r_cal_d <= 1'b0;
        end else begin
            r_err   <= (err_clr ? 2'b00 : r_err) | w_err_new;
            r_cal_d <= cal_done;
        end
    end

    assign qdr_wr_cmd     = r_wr_cmd;
    assign qdr_wr_addr    = r_wr_addr;
    assign qdr_wr_data    = r_wr_data;
    assign qdr_rd_cmd     = r_rd_cmd;
    assign qdr_rd_addr    = r_rd_addr;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_data       = r_rsp_data;
    assign err_flags      = r_err;
    assign rd_outstanding = r_count;

endmodule
`default_nettype wire

// File: tb/tb_qdrii_user_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_qdrii_user_arbiter
// Purpose : Directed plus randomized bench with a queue-based reference model
//           and a fixed-latency QDRII read-return model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_qdrii_user_arbiter;

    localparam int N  = 4;
    localparam int AW = 19;
    localparam int DW = 144;
    localparam int TD = 32;
    localparam int TW = $clog2(TD);
    localparam int LAT = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, cal_done, err_clr;
    logic [N-1:0]    req_wr_valid, req_rd_valid;
    logic [N*AW-1:0] req_wr_addr, req_rd_addr;
    logic [N*DW-1:0] req_wr_data;
    logic            qdr_wr_full, qdr_rd_full, qdr_rd_valid;
    logic [DW-1:0]   qdr_rd_data;
    logic [N-1:0]    req_wr_ready, req_rd_ready, rsp_valid;
    logic [DW-1:0]   rsp_data, qdr_wr_data;
    logic            qdr_wr_cmd, qdr_rd_cmd;
    logic [AW-1:0]   qdr_wr_addr, qdr_rd_addr;
    logic [1:0]      err_flags;
    logic [TW:0]     rd_outstanding;

    qdrii_user_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst_n(rst_n), .cal_done(cal_done),
        .req_wr_valid(req_wr_valid), .req_wr_ready(req_wr_ready),
        .req_wr_addr(req_wr_addr), .req_wr_data(req_wr_data),
        .req_rd_valid(req_rd_valid), .req_rd_ready(req_rd_ready),
        .req_rd_addr(req_rd_addr), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .qdr_wr_cmd(qdr_wr_cmd), .qdr_wr_addr(qdr_wr_addr), .qdr_wr_data(qdr_wr_data),
        .qdr_wr_full(qdr_wr_full), .qdr_rd_cmd(qdr_rd_cmd), .qdr_rd_addr(qdr_rd_addr),
        .qdr_rd_full(qdr_rd_full), .qdr_rd_valid(qdr_rd_valid), .qdr_rd_data(qdr_rd_data),
        .err_flags(err_flags), .err_clr(err_clr), .rd_outstanding(rd_outstanding)
    );

    typedef struct { int req; logic [AW-1:0] addr; } tag_t;
    typedef struct { logic [AW-1:0] addr; int due; } pend_t;

    tag_t  tagq[$];
    pend_t pend[$];

    int vectors = 0, miscompares = 0, cyc = 0;
    int m_wr_ptr, m_rd_ptr, wg, rg, nrsp;
    logic [1:0] m_err;
    logic m_cal_prev, e_known = 1'b0;
    logic e_wr_cmd, e_rd_cmd;
    logic [AW-1:0] e_wr_addr, e_rd_addr;
    logic [DW-1:0] e_wr_data, e_rsp_data;
    logic [N-1:0] e_rsp_valid, e_wr_rdy, e_rd_rdy, last_rsp = '0;
    logic mem_hold = 1'b0, mem_force = 1'b0, inject_orphan = 1'b0;
    logic [N-1:0] one = 1;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        d = '0;
        d[AW-1:0] = a;
        d[DW-1 -: AW] = ~a;
        return d;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [159:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return w[DW-1:0];
    endfunction

    // Round-robin: first valid requester at or after the start index
    function automatic int pick(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++)
            if (v[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin
            req_wr_addr[i*AW +: AW] = AW'($urandom);
            req_wr_data[i*DW +: DW] = rand_data();
            req_rd_addr[i*AW +: AW] = AW'($urandom);
        end
    endtask

    task automatic mem_drive();
        qdr_rd_valid = 1'b0;
        qdr_rd_data  = '0;
        if (inject_orphan) begin
            qdr_rd_valid = 1'b1;
            qdr_rd_data  = rand_data();
        end else if (pend.size() > 0 && (mem_force || (!mem_hold && pend[0].due <= cyc))) begin
            qdr_rd_valid = 1'b1;
            qdr_rd_data  = mem_fn(pend[0].addr);
            pend.delete(0);
        end
    endtask

    task automatic model_update();
        logic [1:0] nerr;
        tag_t t;
        if (!rst_n) begin
            m_wr_ptr = 0; m_rd_ptr = 0; tagq.delete(); m_err = 2'b00; m_cal_prev = 1'b0;
            e_wr_cmd = 1'b0; e_rd_cmd = 1'b0; e_wr_addr = '0; e_rd_addr = '0;
            e_wr_data = '0; e_rsp_data = '0; e_rsp_valid = '0;
        end else begin
            nerr = 2'b00;
            if (m_cal_prev && !cal_done && tagq.size() != 0) nerr[1] = 1'b1;
            e_rsp_valid = '0;
            if (qdr_rd_valid) begin
                if (tagq.size() == 0) nerr[0] = 1'b1;
                else begin
                    t = tagq.pop_front();
                    e_rsp_valid[t.req] = 1'b1;
                    e_rsp_data = mem_fn(t.addr);
                end
            end
            m_err = (err_clr ? 2'b00 : m_err) | nerr;
            e_wr_cmd = (wg >= 0);
            if (wg >= 0) begin
                e_wr_addr = req_wr_addr[wg*AW +: AW];
                e_wr_data = req_wr_data[wg*DW +: DW];
                m_wr_ptr  = (wg + 1) % N;
            end
            e_rd_cmd = (rg >= 0);
            if (rg >= 0) begin
                e_rd_addr = req_rd_addr[rg*AW +: AW];
                t.req = rg; t.addr = e_rd_addr;
                tagq.push_back(t);
                m_rd_ptr = (rg + 1) % N;
            end
            m_cal_prev = cal_done;
        end
        e_known = 1'b1;
    endtask

    task automatic settle();
        pend_t p;
        mem_drive();
        #1;
        if (e_known) begin
            chk("wr_cmd", qdr_wr_cmd, e_wr_cmd);
            chk("wr_addr", qdr_wr_addr, e_wr_addr);
            chk("wr_data", qdr_wr_data, e_wr_data);
            chk("rd_cmd", qdr_rd_cmd, e_rd_cmd);
            chk("rd_addr", qdr_rd_addr, e_rd_addr);
            chk("rsp_valid", rsp_valid, e_rsp_valid);
            chk("rsp_data", rsp_data, e_rsp_data);
            chk("err_flags", err_flags, m_err);
            chk("rd_outstanding", rd_outstanding, tagq.size());
        end
        if (qdr_rd_cmd === 1'b1) begin
            p.addr = qdr_rd_addr; p.due = cyc + LAT;
            pend.push_back(p);
        end
        wg = -1; rg = -1;
        if (rst_n) begin
            if (cal_done && !qdr_wr_full) wg = pick(req_wr_valid, m_wr_ptr);
            if (cal_done && !qdr_rd_full && tagq.size() < TD) rg = pick(req_rd_valid, m_rd_ptr);
        end
        e_wr_rdy = (wg < 0) ? '0 : one << wg;
        e_rd_rdy = (rg < 0) ? '0 : one << rg;
        chk("wr_ready", req_wr_ready, e_wr_rdy);
        chk("rd_ready", req_rd_ready, e_rd_rdy);
        model_update();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic check_alt();
        logic [N-1:0] e;
        if (rsp_valid !== '0) begin
            e = (last_rsp == 4'b0010) ? 4'b1000 : 4'b0010;
            chk("rsp_alternate", rsp_valid, e);
            chk("rsp_data_addr", rsp_data, mem_fn((e == 4'b0010) ? 19'h100 : 19'h300));
            last_rsp = rsp_valid;
        end
    endtask

    initial begin
        rst_n = 1'b0; cal_done = 1'b0; err_clr = 1'b0;
        req_wr_valid = '1; req_rd_valid = '1;
        qdr_wr_full = 1'b0; qdr_rd_full = 1'b0;
        qdr_rd_valid = 1'b0; qdr_rd_data = '0;
        rand_payload();
        repeat (3) step();

        // Out of reset but uncalibrated: nothing may be granted or issued
        rst_n = 1'b1;
        repeat (3) begin
            settle();
            chk("precal_wr_ready", req_wr_ready, 0);
            chk("precal_rd_ready", req_rd_ready, 0);
            chk("precal_rd_cmd", qdr_rd_cmd, 0);
            advance();
        end

        req_rd_valid = '0;
        cal_done = 1'b1;
        for (int k = 0; k < 5; k++) begin
            rand_payload();
            settle();
            chk("wr_order", req_wr_ready, one << (k % N));
            advance();
        end

        // Requesters 1 and 3 stream reads; writes random alongside
        req_rd_valid = 4'b1010;
        for (int k = 0; k < 40; k++) begin
            rand_payload();
            req_rd_addr[1*AW +: AW] = 19'h100;
            req_rd_addr[3*AW +: AW] = 19'h300;
            req_wr_valid = N'($urandom);
            qdr_wr_full = ($urandom_range(0, 3) == 0);
            settle();
            check_alt();
            advance();
        end

        qdr_wr_full = 1'b0;
        req_wr_valid = '1;
        qdr_rd_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            check_alt();
            chk("rdfull_no_rd_grant", req_rd_ready, 0);
            chk("rdfull_wr_continues", req_wr_ready != '0, 1'b1);
            advance();
        end
        qdr_rd_full = 1'b0;
        repeat (2) begin settle(); check_alt(); advance(); end
        req_rd_valid = '0;
        for (int k = 0; k < 40 && (tagq.size() != 0 || pend.size() != 0); k++) begin
            settle(); check_alt(); advance();
        end
        settle();
        chk("drain_after_stream", rd_outstanding, 0);
        advance();

        // Fill the tag FIFO with no returns
        mem_hold = 1'b1;
        for (int k = 0; k < 200 && tagq.size() < TD; k++) begin
            rand_payload();
            req_rd_valid = N'($urandom_range(1, 15));
            req_wr_valid = N'($urandom);
            step();
        end
        req_rd_valid = '1;
        repeat (2) step();
        settle();
        chk("tag_full_count", rd_outstanding, TD);
        chk("tag_full_no_ready", req_rd_ready, 0);
        advance();
        mem_force = 1'b1;
        settle();
        chk("pop_cycle_no_grant", req_rd_ready, 0);
        advance();
        mem_force = 1'b0;
        settle();
        chk("grant_after_pop", req_rd_ready != '0, 1'b1);
        advance();
        req_rd_valid = '0;
        mem_hold = 1'b0;
        for (int k = 0; k < 100 && (tagq.size() != 0 || pend.size() != 0); k++) step();
        settle();
        chk("drain_after_full", rd_outstanding, 0);
        advance();

        inject_orphan = 1'b1;
        step();
        inject_orphan = 1'b0;
        settle();
        chk("orphan_err", err_flags, 2'b01);
        chk("orphan_no_rsp", rsp_valid, 0);
        advance();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        settle();
        chk("err_cleared", err_flags, 0);
        advance();

        // Calibration lost with four reads outstanding
        mem_hold = 1'b1;
        req_wr_valid = '0;
        for (int k = 0; k < 20 && tagq.size() < 4; k++) begin
            req_rd_valid = 4'b0001;
            step();
        end
        req_rd_valid = '0;
        repeat (2) step();
        cal_done = 1'b0;
        req_wr_valid = '1;
        req_rd_valid = '1;
        settle();
        chk("caldrop_no_wr", req_wr_ready, 0);
        chk("caldrop_no_rd", req_rd_ready, 0);
        advance();
        settle();
        chk("cal_lost_flag", err_flags[1], 1'b1);
        advance();
        mem_hold = 1'b0;
        nrsp = 0;
        for (int k = 0; k < 30; k++) begin
            settle();
            if (rsp_valid !== '0) nrsp++;
            advance();
        end
        chk("caldrop_rsp_count", nrsp, 4);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        for (int k = 0; k < 400; k++) begin
            rand_payload();
            cal_done     = ($urandom_range(0, 19) != 0);
            qdr_wr_full  = ($urandom_range(0, 4) == 0);
            qdr_rd_full  = ($urandom_range(0, 4) == 0);
            req_wr_valid = N'($urandom);
            req_rd_valid = N'($urandom);
            mem_hold     = ($urandom_range(0, 3) == 0);
            err_clr      = ($urandom_range(0, 15) == 0);
            step();
        end
        cal_done = 1'b1; qdr_wr_full = 1'b0; qdr_rd_full = 1'b0;
        req_wr_valid = '0; req_rd_valid = '0; mem_hold = 1'b0; err_clr = 1'b0;
        for (int k = 0; k < 200 && (tagq.size() != 0 || pend.size() != 0); k++) step();
        settle();
        chk("final_drain", rd_outstanding, 0);
        advance();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
